// File: rtl/noc_flit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_flit_pkg
// Brief    : Router flit layout constants, NI FSM state type and header packer.
// Revision : 1.0 - initial release
// ============================================================================
package noc_flit_pkg;

    localparam int FLIT_W         = 64;
    localparam int MCAST_FLAG_BIT = 31;
    localparam int MCAST_MASK_LSB = 26;

    localparam int c_mask_w      = 5;
    localparam int c_coord_w     = 8;
    localparam int c_payload_w   = 32;
    localparam int c_payload_lsb = 32;
    localparam int c_row_lsb     = 8;
    localparam int c_col_lsb     = 0;

    localparam int c_port_n = 0;
    localparam int c_port_e = 1;
    localparam int c_port_s = 2;
    localparam int c_port_w = 3;
    localparam int c_port_l = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DROP = 2'd2
    } ni_state_t;

    // Unicast flits carry row/col and a zero mask; multicast flits the reverse.
    function automatic logic [FLIT_W-1:0] pack_flit(
        input logic [c_payload_w-1:0] payload,
        input logic                   mcast,
        input logic [c_mask_w-1:0]    mask,
        input logic [c_coord_w-1:0]   row,
        input logic [c_coord_w-1:0]   col,
        input logic [5:0]             flag_bit,
        input logic [5:0]             mask_lsb
    );
        logic [FLIT_W-1:0] f;
        f = '0;
        f[c_payload_lsb +: c_payload_w] = payload;
        if (mcast) begin
            f[flag_bit]               = 1'b1;
            f[mask_lsb +: c_mask_w]   = mask;
        end else begin
            f[c_row_lsb +: c_coord_w] = row;
            f[c_col_lsb +: c_coord_w] = col;
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flit_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : flit_out_reg
// Brief    : One-entry valid/ready output register, stable under backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module flit_out_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_free,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Slot can take a new word when empty or when the current one leaves now.
    assign o_free  = !r_valid || i_ready;
    assign o_data  = r_data;
    assign o_valid = r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ni_inject_packer.sv
`default_nettype none
// ============================================================================
// Module   : ni_inject_packer
// Brief    : NI injection stage: descriptor + payload words -> router flits,
//            with illegal-descriptor filtering and injection statistics.
// Revision : 1.0 - initial release
// ============================================================================
module ni_inject_packer #(
    parameter int FLIT_W         = 64,
    parameter int LEN_W          = 4,
    parameter int CNT_W          = 32,
    parameter int MCAST_FLAG_BIT = 31,
    parameter int MCAST_MASK_LSB = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mcast,
    input  logic [4:0]        req_mask,
    input  logic [7:0]        req_row,
    input  logic [7:0]        req_col,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              pld_valid,
    output logic              pld_ready,
    input  logic [31:0]       pld_data,
    output logic [FLIT_W-1:0] ni_flit_out,
    output logic              ni_valid_out,
    input  logic              ni_ready_in,
    output logic [CNT_W-1:0]  cnt_flits,
    output logic [CNT_W-1:0]  cnt_mcast,
    output logic [CNT_W-1:0]  cnt_drops
);

    import noc_flit_pkg::*;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] c_len_one = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [5:0]       c_flag_bit = 6'(MCAST_FLAG_BIT);
    localparam logic [5:0]       c_mask_lsb = 6'(MCAST_MASK_LSB);

    ni_state_t        r_state;
    logic             r_mcast;
    logic [4:0]       r_mask;
    logic [7:0]       r_row;
    logic [7:0]       r_col;
    logic [LEN_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_cnt_flits;
    logic [CNT_W-1:0] r_cnt_mcast;
    logic [CNT_W-1:0] r_cnt_drops;

    logic              w_slot_free;
    logic              w_pld_ready;
    logic              w_req_fire;
    logic              w_pld_fire;
    logic              w_load;
    logic              w_xfer;
    logic              w_drop;
    logic [FLIT_W-1:0] w_flit;

    always_comb begin
        w_pld_ready = 1'b0;
        case (r_state)
            ST_SEND: w_pld_ready = w_slot_free;
            ST_DROP: w_pld_ready = 1'b1;
            default: w_pld_ready = 1'b0;
        endcase
    end

    // Handshakes are masked during reset so nothing is consumed in that cycle.
    assign req_ready  = !rst && (r_state == ST_IDLE);
    assign pld_ready  = !rst && w_pld_ready;
    assign w_req_fire = req_valid && req_ready;
    assign w_pld_fire = pld_valid && pld_ready;
    assign w_load     = w_pld_fire && (r_state == ST_SEND);
    assign w_xfer     = ni_valid_out && ni_ready_in;
    assign w_drop     = w_req_fire &&
                        ((req_len == '0) || (req_mcast && (req_mask == '0)));
    assign w_flit     = FLIT_W'(pack_flit(pld_data, r_mcast, r_mask, r_row, r_col,
                                          c_flag_bit, c_mask_lsb));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mcast     <= 1'b0;
            r_mask      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_fire) begin
                        r_mcast     <= req_mcast;
                        r_mask      <= req_mask;
                        r_row       <= req_row;
                        r_col       <= req_col;
                        r_remaining <= req_len;
                        if (req_len == '0)
                            r_state <= ST_IDLE;
                        else if (req_mcast && (req_mask == '0))
                            r_state <= ST_DROP;
                        else
                            r_state <= ST_SEND;
                    end
                end
                ST_SEND, ST_DROP: begin
                    if (w_pld_fire) begin
                        r_remaining <= r_remaining - c_len_one;
                        if (r_remaining == c_len_one)
                            r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_flits <= '0;
            r_cnt_mcast <= '0;
            r_cnt_drops <= '0;
        end else begin
            if (w_xfer)
                r_cnt_flits <= r_cnt_flits + c_cnt_one;
            if (w_xfer && ni_flit_out[MCAST_FLAG_BIT])
                r_cnt_mcast <= r_cnt_mcast + c_cnt_one;
            if (w_drop)
                r_cnt_drops <= r_cnt_drops + c_cnt_one;
        end
    end

    assign cnt_flits = r_cnt_flits;
    assign cnt_mcast = r_cnt_mcast;
    assign cnt_drops = r_cnt_drops;

    flit_out_reg #(
        .WIDTH (FLIT_W)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_flit),
        .i_ready (ni_ready_in),
        .o_free  (w_slot_free),
        .o_data  (ni_flit_out),
        .o_valid (ni_valid_out)
    );

endmodule
`default_nettype wire
